mem_stage: RTL and testbench

- Pipeline MEM stage. Sits directly downstream of the EX/MEM register and consumes its outputs (inst, MEM_signal, WB_signal, ALUResult, RTdata).
- Performs data-memory loads and stores over a req/ack bus with variable latency.
- Raises a stall to the hazard unit while an access is outstanding.
- Contains the MEM/WB pipeline register feeding writeback and forwarding.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/mem_wb_reg.sv | 57 +++++
 rtl/mem_stage.sv | 146 ++++++++++++++
 tb/tb_mem_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared control-field bit positions and MEM-stage FSM encoding for the pipeline.
package cpu_pkg;

   localparam int MEM_BRANCH  = 2;
   localparam int MEM_READ    = 1;
   localparam int MEM_WRITE   = 0;

   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_e;

   // Loads write rt (I-type); everything else writes rd (R-type).
   function automatic logic [4:0] dest_reg(input logic [31:0] inst, input logic mem_read);
      return mem_read ? inst[20:16] : inst[15:11];
   endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: holds while the stage stalls, a bubble clears the writeback controls.
module mem_wb_reg
   import cpu_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        hold_i,
   input  logic        bubble_i,
   input  logic [31:0] inst_i,
   input  logic [1:0]  WB_signal_i,
   input  logic [31:0] ALUResult_i,
   input  logic [31:0] MemData_i,
   input  logic [4:0]  RDaddr_i,
   output logic [31:0] inst_o,
   output logic [1:0]  WB_signal_o,
   output logic [31:0] ALUResult_o,
   output logic [31:0] MemData_o,
   output logic [4:0]  RDaddr_o
);

   logic [31:0] inst_q;
   logic [1:0]  wb_q, wb_d;
   logic [31:0] alu_q;
   logic [31:0] mdata_q;
   logic [4:0]  rd_q;

   always_comb begin
      wb_d = WB_signal_i;
      if (bubble_i) begin
         wb_d[WB_REGWRITE] = 1'b0;
         wb_d[WB_MEMTOREG] = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         inst_q  <= '0;
         wb_q    <= '0;
         alu_q   <= '0;
         mdata_q <= '0;
         rd_q    <= '0;
      end else if (!hold_i) begin
         inst_q  <= inst_i;
         wb_q    <= wb_d;
         alu_q   <= ALUResult_i;
         mdata_q <= MemData_i;
         rd_q    <= RDaddr_i;
      end
   end

   assign inst_o      = inst_q;
   assign WB_signal_o = wb_q;
   assign ALUResult_o = alu_q;
   assign MemData_o   = mdata_q;
   assign RDaddr_o    = rd_q;

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: data-memory access over a req/ack bus with timeout, stall
// generation for the hazard unit, and the MEM/WB register.
module mem_stage
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
)(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] inst_i,
   input  logic [2:0]  MEM_signal_i,
   input  logic [1:0]  WB_signal_i,
   input  logic [31:0] ALUResult_i,
   input  logic [31:0] RTdata_i,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_ack_i,
   input  logic [31:0] dmem_rdata_i,
   output logic        stall_o,
   output logic        err_o,
   output logic [31:0] inst_o,
   output logic [1:0]  WB_signal_o,
   output logic [31:0] ALUResult_o,
   output logic [31:0] MemData_o,
   output logic [4:0]  RDaddr_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   mem_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             req_q, we_q, err_q, err_d;
   logic [31:0]      addr_q, wdata_q;

   logic        mem_rd, mem_wr, memop, misalign, timeout, issue;
   logic        stall, wb_hold, wb_bubble;
   logic [31:0] mem_data;
   logic        unused_branch;

   assign mem_rd        = MEM_signal_i[MEM_READ];
   assign mem_wr        = MEM_signal_i[MEM_WRITE];
   assign memop         = mem_rd | mem_wr;
   assign misalign      = memop & (ALUResult_i[1:0] != 2'b00);
   assign timeout       = (state_q == WAIT) && !dmem_ack_i && (cnt_q == CNT_LAST);
   assign unused_branch = MEM_signal_i[MEM_BRANCH];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (memop && !misalign)      state_d = WAIT;
         WAIT:    if (dmem_ack_i || timeout)   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // A timeout cycle still reports stall (no ack) but must load the bubble, so hold != stall there.
   always_comb begin
      stall     = 1'b0;
      wb_hold   = 1'b0;
      wb_bubble = 1'b0;
      mem_data  = '0;
      err_d     = 1'b0;
      issue     = 1'b0;
      case (state_q)
         IDLE: begin
            if (misalign) begin
               wb_bubble = 1'b1;
               err_d     = 1'b1;
            end else if (memop) begin
               stall   = 1'b1;
               wb_hold = 1'b1;
               issue   = 1'b1;
            end
         end
         WAIT: begin
            stall = ~dmem_ack_i;
            if (dmem_ack_i) begin
               mem_data = we_q ? 32'h0 : dmem_rdata_i;
            end else if (timeout) begin
               wb_bubble = 1'b1;
               err_d     = 1'b1;
            end else begin
               wb_hold = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= err_d;
         if (issue) begin
            req_q   <= 1'b1;
            we_q    <= mem_wr;
            addr_q  <= ALUResult_i;
            wdata_q <= RTdata_i;
            cnt_q   <= '0;
         end else if (state_q == WAIT) begin
            if (dmem_ack_i || timeout) req_q <= 1'b0;
            else                       cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign dmem_req_o   = req_q;
   assign dmem_we_o    = we_q;
   assign dmem_addr_o  = addr_q;
   assign dmem_wdata_o = wdata_q;
   assign err_o        = err_q;
   // Held-stable inputs may still decode as a memop during reset; stall must read 0 there.
   assign stall_o      = stall & rst_i;

   mem_wb_reg u_mem_wb (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .hold_i      (wb_hold),
      .bubble_i    (wb_bubble),
      .inst_i      (inst_i),
      .WB_signal_i (WB_signal_i),
      .ALUResult_i (ALUResult_i),
      .MemData_i   (mem_data),
      .RDaddr_i    (dest_reg(inst_i, mem_rd)),
      .inst_o      (inst_o),
      .WB_signal_o (WB_signal_o),
      .ALUResult_o (ALUResult_o),
      .MemData_o   (MemData_o),
      .RDaddr_o    (RDaddr_o)
   );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage (TIMEOUT=4): driver issues vectors and pushes expected
// MEM/WB contents and bus requests; negedge monitors pop and compare.
module tb_mem_stage;

  localparam int W  = 104;  // {inst, wb, alu, memdata, rd, err}
  localparam int BW = 65;   // {we, addr, wdata}

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] inst_i = '0;
  logic [2:0]  MEM_signal_i = '0;
  logic [1:0]  WB_signal_i = '0;
  logic [31:0] ALUResult_i = '0;
  logic [31:0] RTdata_i = '0;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        stall_o, err_o;
  logic [31:0] inst_o, ALUResult_o, MemData_o;
  logic [1:0]  WB_signal_o;
  logic [4:0]  RDaddr_o;

  logic [W-1:0]  exp_q[$];
  string         name_q[$];
  logic [BW-1:0] bus_q[$];

  int n_vec  = 0;
  int n_miss = 0;
  bit mon_on = 0;

  mem_stage #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .inst_i       (inst_i),
    .MEM_signal_i (MEM_signal_i),
    .WB_signal_i  (WB_signal_i),
    .ALUResult_i  (ALUResult_i),
    .RTdata_i     (RTdata_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .stall_o      (stall_o),
    .err_o        (err_o),
    .inst_o       (inst_o),
    .WB_signal_o  (WB_signal_o),
    .ALUResult_o  (ALUResult_o),
    .MemData_o    (MemData_o),
    .RDaddr_o     (RDaddr_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor (MEM/WB) ----------------
  logic   stall_last = 1'b0;
  bit     armed = 0;
  logic [W-1:0] exp_v;
  string  nm;

  always @(negedge clk_i) begin
    if (armed && (!stall_last || err_o)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_retire", 256'(inst_o), 256'(32'hFFFF_FFFF));
      end else begin
        exp_v = exp_q.pop_front();
        nm    = name_q.pop_front();
        check({nm, "_memwb"},
              256'({inst_o, WB_signal_o, ALUResult_o, MemData_o, RDaddr_o, err_o}),
              256'(exp_v));
      end
    end
    stall_last = stall_o;
    armed      = mon_on;
  end

  // ---------------- bus monitor ----------------
  logic          req_prev = 1'b0;
  logic [BW-1:0] bus_prev = '0;
  logic [BW-1:0] bus_exp;

  always @(negedge clk_i) begin
    if (dmem_req_o && !req_prev) begin
      if (bus_q.size() == 0) begin
        check("unexpected_req", 256'({dmem_we_o, dmem_addr_o, dmem_wdata_o}), 256'(0));
      end else begin
        bus_exp = bus_q.pop_front();
        check("bus_req", 256'({dmem_we_o, dmem_addr_o, dmem_wdata_o}), 256'(bus_exp));
      end
    end else if (dmem_req_o && req_prev) begin
      check("bus_stable", 256'({dmem_we_o, dmem_addr_o, dmem_wdata_o}), 256'(bus_prev));
    end
    req_prev = dmem_req_o;
    bus_prev = {dmem_we_o, dmem_addr_o, dmem_wdata_o};
  end

  // ---------------- driver ----------------
  // Called at posedge+1. ack_at: WAIT cycle (1-based) carrying ack, 0 = never.
  // e_occ: cycles the instruction spends in the stage, including its release cycle.
  task automatic run_vec(input string name,
                         input logic [31:0] inst, input logic [2:0] mem, input logic [1:0] wb,
                         input logic [31:0] alu, input logic [31:0] rt,
                         input int ack_at, input logic [31:0] rdata, input logic stray,
                         input logic [4:0] e_rd, input logic [1:0] e_wb, input logic [31:0] e_md,
                         input logic e_err, input int e_occ, input int e_req);
    int  n_occ = 0;
    int  n_req = 0;
    bit  released;
    bit  finished = 0;
    inst_i = inst; MEM_signal_i = mem; WB_signal_i = wb; ALUResult_i = alu; RTdata_i = rt;
    exp_q.push_back({inst, e_wb, alu, e_md, e_rd, e_err});
    name_q.push_back(name);
    if (e_req > 0) bus_q.push_back({mem[0], alu, rt});
    for (int c = 0; c < 30; c++) begin
      if (dmem_req_o) begin
        n_req++;
        dmem_ack_i   = (n_req == ack_at);
        dmem_rdata_i = rdata;
      end else begin
        dmem_ack_i   = stray;
        dmem_rdata_i = rdata;
      end
      @(negedge clk_i);
      released = !stall_o;
      @(posedge clk_i);
      #1;
      dmem_ack_i = 1'b0;
      n_occ++;
      if (released || err_o) begin
        finished = 1;
        break;
      end
    end
    check({name, "_done"}, 256'(finished), 256'(1));
    check({name, "_occupancy"}, 256'(n_occ), 256'(e_occ));
    check({name, "_req_cycles"}, 256'(n_req), 256'(e_req));
  endtask

  // ---------------- stimulus ----------------
  int req_seen;

  initial begin
    // Reset with a load presented: every output must read 0, stall included.
    inst_i = 32'h8D09_0000; MEM_signal_i = 3'b010; WB_signal_i = 2'b11; ALUResult_i = 32'h100;
    #1;
    check("reset_outputs",
          256'({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, stall_o, err_o,
                inst_o, WB_signal_o, ALUResult_o, MemData_o, RDaddr_o}), 256'(0));
    repeat (2) @(posedge clk_i);
    #1;
    inst_i = '0; MEM_signal_i = '0; WB_signal_i = '0; ALUResult_i = '0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    mon_on = 1;

    //      name          inst          mem     wb     alu           rt            ack rdata        stray rd     ewb    e_md          err  occ req
    run_vec("rtype",      32'h012A4020, 3'b000, 2'b10, 32'h0000_0005, 32'h0,        0, 32'h0,        0, 5'd8,  2'b10, 32'h0,        0,   1,  0);
    run_vec("lw_ack3",    32'h8D09_0000, 3'b010, 2'b11, 32'h0000_0100, 32'hAAAA_0000, 3, 32'hDEADBEEF, 0, 5'd9,  2'b11, 32'hDEADBEEF, 0,   4,  3);
    run_vec("sw_ack1",    32'hAD0A_0004, 3'b001, 2'b00, 32'h0000_0104, 32'h1234_5678, 1, 32'hFFFF_FFFF, 0, 5'd0,  2'b00, 32'h0,        0,   2,  1);
    run_vec("lw_misalign",32'h8D0B_0002, 3'b010, 2'b11, 32'h0000_0102, 32'h0,        0, 32'h0,        0, 5'd11, 2'b00, 32'h0,        1,   1,  0);
    run_vec("sub_after",  32'h014B_6022, 3'b000, 2'b10, 32'hFFFF_FFF0, 32'h0,        0, 32'h0,        0, 5'd12, 2'b10, 32'h0,        0,   1,  0);
    run_vec("lw_timeout", 32'h8D0C_0008, 3'b010, 2'b11, 32'h0000_0108, 32'h0,        0, 32'h5555_5555, 0, 5'd12, 2'b00, 32'h0,        1,   5,  4);
    run_vec("lw_ack4",    32'h8D0D_000C, 3'b010, 2'b11, 32'h0000_010C, 32'h0,        4, 32'h0BADF00D, 0, 5'd13, 2'b11, 32'h0BADF00D, 0,   5,  4);
    run_vec("rd_wr_both", 32'hAD0E_0010, 3'b011, 2'b00, 32'h0000_0110, 32'hCAFEBABE, 2, 32'h1111_1111, 0, 5'd14, 2'b00, 32'h0,        0,   3,  2);
    run_vec("branch_ack", 32'h012A4020, 3'b100, 2'b10, 32'h0000_0003, 32'h0,        0, 32'h2222_2222, 1, 5'd8,  2'b10, 32'h0,        0,   1,  0);
    run_vec("sw_misalign",32'hAD11_0001, 3'b001, 2'b00, 32'h0000_0105, 32'h7777_7777, 0, 32'h0,        0, 5'd0,  2'b00, 32'h0,        1,   1,  0);
    run_vec("nop",        32'h0,        3'b000, 2'b00, 32'h0,        32'h0,        0, 32'h0,        0, 5'd0,  2'b00, 32'h0,        0,   1,  0);
    mon_on = 0;

    repeat (2) @(posedge clk_i);
    #1;
    check("exp_q_drained", 256'(exp_q.size()), 256'(0));
    check("bus_q_drained", 256'(bus_q.size()), 256'(0));

    // Reset asserted mid-access: request drops at once and nothing completes afterwards.
    inst_i = 32'h8D0F_0000; MEM_signal_i = 3'b010; WB_signal_i = 2'b11;
    ALUResult_i = 32'h200; RTdata_i = 32'h0;
    bus_q.push_back({1'b0, 32'h200, 32'h0});
    repeat (3) begin @(posedge clk_i); #1; end
    check("midaccess_req_high", 256'(dmem_req_o), 256'(1));
    #2;
    rst_i = 1'b0;
    #1;
    check("midaccess_reset_outputs",
          256'({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, stall_o, err_o,
                inst_o, WB_signal_o, ALUResult_o, MemData_o, RDaddr_o}), 256'(0));
    inst_i = '0; MEM_signal_i = '0; WB_signal_i = '0; ALUResult_i = '0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    req_seen = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (dmem_req_o) req_seen++;
    end
    check("post_reset_no_req", 256'(req_seen), 256'(0));
    check("post_reset_memwb",
          256'({inst_o, WB_signal_o, MemData_o, err_o, stall_o}), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
